// File: rtl/unpacked_array_serializer_pkg.sv
// Shared definitions for the unpacked array serializer/deserializer pair:
// FSM state encoding and the beat-count geometry helpers.
package unpacked_array_serializer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } ser_state_t;

    function automatic int calc_beats(input int in_size, input int out_size);
        return in_size / out_size;
    endfunction

    // A single-beat configuration still needs a one-bit counter.
    function automatic int calc_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/unpacked_array_serializer_beat_select.sv
// Combinational selection of OUT_SIZE consecutive elements of the held
// array, chosen by beat index (beat k carries elements k*OUT_SIZE ..).
module unpacked_beat_select
    import unpacked_array_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IN_SIZE    = 16,
    parameter int OUT_SIZE   = 4,
    parameter int CNT_W      = 2
) (
    input  logic [DATA_WIDTH-1:0] held      [IN_SIZE],
    input  logic [CNT_W-1:0]      beat_idx,
    output logic [DATA_WIDTH-1:0] beat_data [OUT_SIZE]
);

    localparam int BEATS = calc_beats(IN_SIZE, OUT_SIZE);

    // One-hot compare per beat keeps every array index a constant.
    always_comb begin
        for (int j = 0; j < OUT_SIZE; j++) begin
            beat_data[j] = '0;
        end
        for (int k = 0; k < BEATS; k++) begin
            if (beat_idx == CNT_W'(k)) begin
                for (int j = 0; j < OUT_SIZE; j++) begin
                    beat_data[j] = held[k*OUT_SIZE + j];
                end
            end
        end
    end

endmodule

// File: rtl/unpacked_array_serializer.sv
// Serializes one IN_SIZE-element unpacked array into IN_SIZE/OUT_SIZE beats
// of OUT_SIZE elements, flagging the final beat with out_last.
module unpacked_array_serializer
    import unpacked_array_serializer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int IN_SIZE    = 16,
    parameter int OUT_SIZE   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data  [IN_SIZE],
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data [OUT_SIZE],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);

    localparam int BEATS = calc_beats(IN_SIZE, OUT_SIZE);
    localparam int CNT_W = calc_cnt_w(BEATS);

    if ((IN_SIZE % OUT_SIZE) != 0) begin : g_bad_geometry
        $error("unpacked_array_serializer: IN_SIZE must be a multiple of OUT_SIZE");
    end

    ser_state_t            state;
    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] held_p1 [IN_SIZE];
    logic                  in_accept;
    logic                  out_accept;

    // A new array may enter while the last beat of the current one leaves.
    assign in_ready   = !rst && ((state == ST_IDLE) || (out_ready && out_last));
    assign in_accept  = in_valid && in_ready;
    assign out_accept = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            held_p1   <= '{default: '0};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_accept) begin
                        held_p1   <= in_data;
                        cnt       <= '0;
                        state     <= ST_SEND;
                        out_valid <= 1'b1;
                        out_last  <= (BEATS == 1);
                    end
                end
                ST_SEND: begin
                    if (out_accept) begin
                        if (out_last) begin
                            cnt <= '0;
                            if (in_accept) begin
                                held_p1  <= in_data;
                                out_last <= (BEATS == 1);
                            end else begin
                                state     <= ST_IDLE;
                                out_valid <= 1'b0;
                                out_last  <= 1'b0;
                            end
                        end else begin
                            cnt      <= cnt + CNT_W'(1);
                            out_last <= (cnt == CNT_W'(BEATS - 2));
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    // ---- output stage: beat mux from holding register ----
    unpacked_beat_select #(
        .DATA_WIDTH(DATA_WIDTH),
        .IN_SIZE   (IN_SIZE),
        .OUT_SIZE  (OUT_SIZE),
        .CNT_W     (CNT_W)
    ) u_beat_select (
        .held     (held_p1),
        .beat_idx (cnt),
        .beat_data(out_data)
    );

endmodule

// File: doc/unpacked_array_serializer.md
Name: unpacked_array_serializer

Overview:
- Transmit-side counterpart to the parallel unpacked register slice.
- Accepts a full unpacked array of IN_SIZE elements in one valid/ready handshake.
- Emits it as IN_SIZE/OUT_SIZE consecutive beats of OUT_SIZE elements each, with a last flag.
- Sits between wide parallel compute stages and narrower streaming consumers; the matching deserializer rebuilds the array.

Parameters:
- DATA_WIDTH, 32, width of one element.
- IN_SIZE, 16, elements per input array.
- OUT_SIZE, 4, elements per output beat. IN_SIZE % OUT_SIZE must be 0; elaboration error otherwise.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_data  input  [DATA_WIDTH-1:0] x IN_SIZE unpacked  parallel array.
- in_valid  input  1  in_data valid.
- in_ready  output  1  serializer can accept an array this cycle.
- out_data  output  [DATA_WIDTH-1:0] x OUT_SIZE unpacked  current beat.
- out_valid  output  1  out_data valid.
- out_ready  input  1  consumer accepts the beat.
- out_last  output  1  high on the final beat of an array.

Behaviour:
- Reset is synchronous and active-high on clk.
  - In reset: out_valid=0, out_last=0, beat counter=0, state=IDLE.
  - Holding register and out_data cleared to 0; in_ready=0 while rst is high.
  - Reset mid-array discards remaining beats; no partial output after rst deasserts.
- Constants:
  - BEATS = IN_SIZE/OUT_SIZE.
  - CNT_W = max(1, $clog2(BEATS)).
- States:
  - IDLE: no array held.
  - SEND: array held, beats outstanding.
- Input accept: in_valid && in_ready.
  - The whole array is captured into the holding register.
  - Counter is set to 0; state goes to SEND.
- in_ready is combinational: (state==IDLE) || (state==SEND && out_ready && out_last) when not in reset. This gives zero-bubble back-to-back arrays.
- Beat mapping: beat k, element j is out_data[j] = held[k*OUT_SIZE + j]. Beat 0 carries elements 0..OUT_SIZE-1.
- out_valid = (state==SEND). out_last = (state==SEND && counter==BEATS-1).
- Output accept: out_valid && out_ready.
  - Not last: counter increments.
  - Last with a simultaneous input accept: reload the new array, counter=0, stay in SEND.
  - Last without an input accept: go to IDLE, counter=0.
- Stall: with out_ready low, out_data, out_valid, out_last and counter hold stable. No valid drop or data change while stalled.
- Latency: first beat is visible one cycle after the input accept.
- Throughput: one beat per cycle; sustained 100% output utilisation with continuous in_valid.
- BEATS==1 (OUT_SIZE==IN_SIZE): behaves as a one-deep register slice with out_last permanently high whenever out_valid.
- in_data is ignored unless an input accept happens. in_valid does not need to stay asserted after acceptance.

Decomposition:
- Shared package: function computing BEATS and CNT_W from IN_SIZE/OUT_SIZE, reused by the matching deserializer.
- One natural sub-module, unpacked_beat_select: combinational mux choosing OUT_SIZE elements of the held array by counter index.
- Top level holds the FSM, counter and holding register.

Test Plan:
- Single array, defaults (16/4), out_ready=1, in_data[i]=i+1:
  - beats {1,2,3,4},{5,6,7,8},{9,10,11,12},{13,14,15,16} on 4 consecutive cycles.
  - out_last only on the 4th beat; in_ready high on the 4th beat cycle.
- Back-to-back: two arrays A (0x100+i) and B (0x200+i), in_valid held high, out_ready=1:
  - 8 contiguous valid beats, no bubble.
  - B accepted exactly on the cycle A's last beat is accepted.
- Backpressure: out_ready low for 3 cycles on beat 2:
  - out_data={9,10,11,12} and out_valid stay stable throughout; in_ready stays 0.
  - Sequence resumes unchanged.
- Reset mid-array: assert rst after beat 1 is accepted:
  - next cycle out_valid=0, in_ready=0.
  - After release in_ready=1 and a new array starts at beat 0.
- BEATS==1 configuration (IN_SIZE=OUT_SIZE=4), random in_valid/out_ready:
  - every output has out_last=1.
  - scoreboard matches arrays in order with no loss or duplication.
- Random stress (defaults, 1000 arrays, random valid/ready): scoreboard reconstructs every array in order; exactly one out_last per array.
